// File: rtl/ser_key_sequencer_if.sv
// Bus bundle between the serial-key sequencer (master) and its controller/decoder side (slave).
interface ser_key_if;
    logic        start;
    logic        abort;
    logic [15:0] key;
    logic [4:0]  nbits;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic        sser_n;
    logic        ba13;
    logic        ba12;
    logic [3:0]  ba_nib;
    logic        br_w;
    logic        ser_clk;
    logic        sdrd;

    modport master (
        input  start, abort, key, nbits, sdrd,
        output busy, done, err, rdata, sser_n, ba13, ba12, ba_nib, br_w, ser_clk
    );

    modport slave (
        output start, abort, key, nbits, sdrd,
        input  busy, done, err, rdata, sser_n, ba13, ba12, ba_nib, br_w, ser_clk
    );
endinterface

// File: rtl/ser_key_sequencer.sv
// Drives the serial-key decoder access window: 4-nibble unlock preamble, then N strobed
// reads whose SDRD bits are shifted MSB-first into rdata.
module ser_key_sequencer #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned HOLD_CYC    = 2,
    parameter logic [3:0]  READ_NIBBLE = 4'h0
) (
    input  logic clk,
    input  logic rst_n,
    ser_key_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_READ, S_DONE} state_t;

    localparam logic [4:0] STROBE_C = 5'(SETUP_CYC);
    localparam logic [4:0] LAST_C   = 5'(SETUP_CYC + HOLD_CYC);

    state_t      state_q, state_d;
    logic [4:0]  cyc_q, cyc_d;
    logic [3:0]  acc_q, acc_d;
    logic [15:0] key_q, key_d;
    logic [4:0]  nbits_q, nbits_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        bad_done_q, bad_done_d;

    logic        active;
    logic        last_cyc;
    logic [3:0]  key_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            acc_q      <= '0;
            key_q      <= '0;
            nbits_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            bad_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            acc_q      <= acc_d;
            key_q      <= key_d;
            nbits_q    <= nbits_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            bad_done_q <= bad_done_d;
        end
    end

    assign active   = (state_q == S_PRE) || (state_q == S_READ);
    assign last_cyc = (cyc_q == LAST_C);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        acc_d      = acc_q;
        key_d      = key_q;
        nbits_d    = nbits_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        bad_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.nbits != 5'd0 && bus.nbits <= 5'd16) begin
                        key_d   = bus.key;
                        nbits_d = bus.nbits;
                        err_d   = 1'b0;
                        rdata_d = '0;
                        cyc_d   = '0;
                        acc_d   = '0;
                        state_d = S_PRE;
                    end else begin
                        err_d      = 1'b1;
                        bad_done_d = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (bus.abort) begin
                    err_d   = 1'b1;
                    cyc_d   = '0;
                    acc_d   = '0;
                    state_d = S_DONE;
                end else if (last_cyc) begin
                    cyc_d = '0;
                    if (acc_q == 4'd3) begin
                        acc_d   = '0;
                        state_d = S_READ;
                    end else begin
                        acc_d = acc_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            S_READ: begin
                // abort wins over a sample due on this same edge
                if (bus.abort) begin
                    err_d   = 1'b1;
                    cyc_d   = '0;
                    acc_d   = '0;
                    state_d = S_DONE;
                end else if (last_cyc) begin
                    rdata_d = {rdata_q[14:0], bus.sdrd};
                    cyc_d   = '0;
                    if ({1'b0, acc_q} + 5'd1 == nbits_q) begin
                        acc_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        acc_d = acc_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (acc_q[1:0])
            2'd0:    key_nib = key_q[15:12];
            2'd1:    key_nib = key_q[11:8];
            2'd2:    key_nib = key_q[7:4];
            default: key_nib = key_q[3:0];
        endcase
    end

    // Bus outputs decode straight from async-reset registers so reset clears them at once.
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE) || bad_done_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.sser_n  = ~active;
    assign bus.ba13    = ~active;
    assign bus.ba12    = active;
    assign bus.br_w    = active;
    assign bus.ser_clk = active && (cyc_q == STROBE_C);
    assign bus.ba_nib  = (state_q == S_PRE)  ? key_nib :
                         (state_q == S_READ) ? READ_NIBBLE : 4'h0;

endmodule

// File: tb/tb_ser_key_sequencer.sv
// Scoreboard bench for ser_key_sequencer: stimulus queues expected nibbles/results,
// a negedge monitor pops and compares as the DUT strobes and signals done.
module tb_ser_key_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ser_key_if bus ();

    ser_key_sequencer #(
        .SETUP_CYC  (2),
        .HOLD_CYC   (2),
        .READ_NIBBLE(4'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          pulses;
        int          busy_cyc;
    } txn_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } snap_t;

    txn_t        exp_q[$];
    logic [3:0]  nib_q[$];
    snap_t       snap_q[$];
    logic [15:0] pat = '0;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Decoder stand-in: after each read strobe, present the next pattern bit MSB first.
    int pcount = 0;
    always @(negedge clk) begin
        if (!bus.busy) begin
            pcount   = 0;
            bus.sdrd = 1'b0;
        end else if (bus.ser_clk) begin
            if (pcount >= 4 && pcount < 20) bus.sdrd = pat[4'(19 - pcount)];
            pcount++;
        end
    end

    int pulses = 0;
    int bcyc   = 0;
    int wd     = 0;
    always @(negedge clk) begin
        snap_t      s;
        txn_t       t;
        logic [3:0] n;
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            check(s.name, s.act, s.exp);
        end
        if (!rst_n) begin
            pulses = 0;
            bcyc   = 0;
        end
        if (bus.busy && !bus.done)
            check("bus_active", {28'b0, bus.sser_n, bus.ba13, bus.ba12, bus.br_w}, 32'h3);
        else
            check("bus_idle", {23'b0, bus.sser_n, bus.ba13, bus.ba12, bus.br_w,
                               bus.ser_clk, bus.ba_nib}, 32'h180);
        if (bus.ser_clk) begin
            pulses++;
            if (nib_q.size() == 0) begin
                check("strobe_unexpected", {31'b0, bus.ser_clk}, 32'h0);
            end else begin
                n = nib_q.pop_front();
                check("ba_nib", {28'b0, bus.ba_nib}, {28'b0, n});
            end
        end
        if (bus.busy) bcyc++;
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", {31'b0, bus.done}, 32'h0);
            end else begin
                t = exp_q.pop_front();
                check("rdata", {16'b0, bus.rdata}, {16'b0, t.rdata});
                check("err", {31'b0, bus.err}, {31'b0, t.err});
                check("strobes", pulses, t.pulses);
                check("busy_cycles", bcyc, t.busy_cyc);
            end
            pulses = 0;
            bcyc   = 0;
            wd     = 0;
        end
        if (exp_q.size() > 0) begin
            wd++;
            if (wd > 300) begin
                check("timeout", wd, 32'h0);
                exp_q.delete();
                nib_q.delete();
                wd = 0;
            end
        end
    end

    task automatic push_txn(input logic [15:0] k, input int nb, input logic [15:0] rd,
                            input logic e, input int npulse, input int nbusy);
        txn_t t;
        if (nb >= 1 && nb <= 16) begin
            nib_q.push_back(k[15:12]);
            nib_q.push_back(k[11:8]);
            nib_q.push_back(k[7:4]);
            nib_q.push_back(k[3:0]);
            for (int i = 0; i < nb; i++) nib_q.push_back(4'h0);
        end
        t.rdata    = rd;
        t.err      = e;
        t.pulses   = npulse;
        t.busy_cyc = nbusy;
        exp_q.push_back(t);
    endtask

    task automatic start_txn(input logic [15:0] k, input logic [4:0] nb, input logic [15:0] p);
        bus.key   = k;
        bus.nbits = nb;
        pat       = p;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        snap_t s;
        int    seen;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.key   = '0;
        bus.nbits = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        s.name = "reset_status";
        s.act  = {13'b0, bus.busy, bus.done, bus.err, bus.rdata};
        s.exp  = 32'h0;
        snap_q.push_back(s);

        // Preamble A,5,C,3 then reads of 1,0,1,1,0,0,1,0: done 61 cycles after acceptance.
        push_txn(16'hA5C3, 8, 16'h00B2, 1'b0, 12, 61);
        start_txn(16'hA5C3, 5'd8, 16'hB200);
        wait_empty();

        push_txn(16'h0F0F, 16, 16'hFFFF, 1'b0, 20, 101);
        start_txn(16'h0F0F, 5'd16, 16'hFFFF);
        wait_empty();

        // Illegal lengths: no bus activity, done pulse, err set, rdata retained.
        push_txn(16'h1111, 0, 16'hFFFF, 1'b1, 0, 0);
        start_txn(16'h1111, 5'd0, 16'h0000);
        wait_empty();
        push_txn(16'h2222, 17, 16'hFFFF, 1'b1, 0, 0);
        start_txn(16'h2222, 5'd17, 16'h0000);
        wait_empty();

        push_txn(16'h1E2D, 1, 16'h0000, 1'b0, 5, 26);
        start_txn(16'h1E2D, 5'd1, 16'h0000);
        wait_empty();

        // Abort on the last HOLD cycle of the 3rd read: its sample is dropped.
        push_txn(16'h9876, 8, 16'h0002, 1'b1, 7, 36);
        void'(nib_q.pop_back());
        repeat (4) void'(nib_q.pop_back());
        start_txn(16'h9876, 5'd8, 16'hB200);
        seen = 0;
        for (int i = 0; i < 200 && seen < 7; i++) begin
            @(negedge clk);
            if (bus.ser_clk) seen++;
        end
        @(posedge clk);
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        wait_empty();

        // Reset during the first preamble strobe.
        nib_q.push_back(4'h1);
        start_txn(16'h1234, 5'd4, 16'h0000);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ser_clk) break;
        end
        #1 rst_n = 1'b0;
        #1;
        s.name = "rst_drop";
        s.act  = {29'b0, bus.ser_clk, bus.busy, bus.sser_n};
        s.exp  = 32'h1;
        snap_q.push_back(s);
        nib_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        push_txn(16'h1234, 4, 16'h0005, 1'b0, 8, 41);
        start_txn(16'h1234, 5'd4, 16'h5000);
        wait_empty();

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ser_key_sequencer.md
Name: ser_key_sequencer

Overview:
- Bus-side master that drives the serial-key decoder's access window and collects the bits it returns.
- On a start request it issues a fixed 4-access unlock preamble, each access carrying one key nibble on BA7..BA4.
- It then issues N read accesses and shifts the returned SDRD bit of each into a result word.
- Sits directly upstream of the key decoder GAL, generating its SSER/BA13/BA12/BA7..BA4/BR_W inputs and its clk strobe, and consuming SDRD.

Parameters:
- SETUP_CYC, 2, cycles the address/select are held stable before the strobe (1..15).
- HOLD_CYC, 2, cycles after the strobe before SDRD is sampled and the next access starts (1..15).
- READ_NIBBLE, 4'h0, BA7..BA4 value driven during read accesses.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transaction; accepted only in IDLE
- abort  in  1  terminate the current transaction
- key  in  16  preamble nibbles; key[15:12] is sent first, key[3:0] last
- nbits  in  5  number of read accesses, legal 1..16
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at the end of a transaction
- err  out  1  sticky: illegal nbits, or abort; cleared by the next accepted start
- rdata  out  16  collected bits, right-justified, first bit most significant
- sser_n  out  1  serial window select, active low
- ba13  out  1  0 while active, 1 in IDLE
- ba12  out  1  1 while active, 0 in IDLE
- ba_nib  out  4  BA7..BA4
- br_w  out  1  1 while active (read direction), 0 in IDLE
- ser_clk  out  1  strobe to decoder clock, one cycle high per access
- sdrd  in  1  serial data from decoder

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy=0, done=0, err=0, rdata=0, sser_n=1, ba13=1, ba12=0, ba_nib=0, br_w=0, ser_clk=0.
  - All counters cleared.
- Start acceptance:
  - start in IDLE with nbits in 1..16: latch key and nbits, clear err and rdata, go to PRE.
  - start in IDLE with nbits=0 or >16: set err, pulse done next cycle, stay IDLE.
  - start while busy is ignored.
- Access timing (PRE and READ):
  - Each access is SETUP_CYC cycles with ser_clk=0, then 1 cycle with ser_clk=1, then HOLD_CYC cycles with ser_clk=0.
  - An access is therefore SETUP_CYC+1+HOLD_CYC cycles; defaults give 5.
  - sser_n=0, ba13=0, ba12=1, br_w=1 from the first PRE cycle through the last READ cycle. There are no gaps between accesses.
  - ba_nib changes only on the first SETUP cycle of an access.
- PRE:
  - 4 accesses carrying key[15:12], key[11:8], key[7:4], key[3:0] in that order.
  - SDRD is ignored.
- READ:
  - nbits accesses with ba_nib=READ_NIBBLE.
  - On the last HOLD cycle of each access: rdata <= {rdata[14:0], sdrd}.
- Completion:
  - After the last READ access, go to DONE for 1 cycle: done=1, bus returns to IDLE values, busy=0 from the next cycle.
  - busy=1 from the cycle after start acceptance through the DONE cycle.
- Abort:
  - abort in PRE or READ: next cycle is DONE with err=1.
  - rdata holds the bits already collected and is not shifted further.
  - abort takes priority over a sample scheduled in the same cycle: that sample is dropped.
  - abort in IDLE or DONE has no effect.
- Total transaction length (defaults): (4+nbits)*5 cycles active + 1 DONE cycle.
- Reset mid-transaction: all outputs take reset values immediately; no partial strobe. ser_clk falls asynchronously.
- rdata is held until the next accepted start.

Test Plan:
- Reset, then idle 10 cycles -> sser_n=1, ba13=1, ba12=0, br_w=0, ser_clk=0, busy=0.
- key=16'hA5C3, nbits=8, sdrd tied to pattern 1,0,1,1,0,0,1,0 -> ba_nib on ser_clk pulses: A,5,C,3, then eight 0s; rdata=16'h00B2; done at cycle 61 after start; err=0.
- nbits=16, sdrd=1 constant -> rdata=16'hFFFF; exactly 20 ser_clk pulses; busy high for 101 cycles.
- nbits=0, then separately nbits=17 -> no bus activity, err=1, one done pulse each; a following legal start clears err.
- nbits=8, abort asserted during the 3rd read access HOLD phase -> rdata holds 2 bits, err=1, done next cycle, bus returns to idle values.
- rst_n pulled low during the PRE ser_clk cycle -> ser_clk drops immediately; after release, state is IDLE and a new start completes normally.
